// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_pkg                                                       |
// | Purpose  : Shared encodings for the cache/memory arbiter: FSM state enum   |
// |            and fill-owner enum.                                            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_blk_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : blk_addr_gen                                                    |
// | Purpose  : Block read address generator. Counts issued words while         |
// |            i_advance is high and forms base + 2*count (byte addressed,     |
// |            wrapping modulo 2^ADDR_W). Counter returns to 0 when idle.      |
// | Ports    : clk, rst_n        clock, async active-low reset                  |
// |            i_advance         high during each issue cycle                  |
// |            i_base            block base address                            |
// |            o_addr            current read address                          |
// |            o_last            current word is the last of the block         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module blk_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int c_CNT_W = $clog2(BLK_WORDS);

  logic [c_CNT_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0]  w_offset;

  // Power-of-two block size lets the counter wrap back to 0 on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
    end else if (i_advance) begin
      r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
    end else begin
      r_issue_cnt <= '0;
    end
  end

  assign w_offset = {{(ADDR_W - c_CNT_W - 1){1'b0}}, r_issue_cnt, 1'b0};
  assign o_addr   = i_base + w_offset;
  assign o_last   = (r_issue_cnt == {c_CNT_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_mem_arbiter                                               |
// | Purpose  : Shares one memory port between I-cache block fills, D-cache     |
// |            block fills and D-cache write-through writes. Writes win in     |
// |            IDLE; fills read BLK_WORDS consecutive words and forward the    |
// |            returned data to the owning cache.                              |
// | Config   : ARB_ROUND_ROBIN_EN - when defined, simultaneous fill requests   |
// |            alternate between caches (D first after reset); otherwise the   |
// |            D-cache always wins.                                            |
// | Ports    : clk, rst_n                     clock, async active-low reset     |
// |            i_miss_req/i_miss_addr         I-cache fill request             |
// |            d_miss_req/d_miss_addr         D-cache fill request             |
// |            d_wr_req/addr/data, d_wr_ack   write-through request / issued   |
// |            mem_enable/wr/addr/data_out    memory command port              |
// |            mem_data_in/mem_data_valid     memory read return               |
// |            fill_data, *_fill_valid,       forwarded fill word              |
// |            fill_word_num, *_fill_done     word index / block complete      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8,
  parameter int MEM_LAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_miss_req,
  input  logic [ADDR_W-1:0]            i_miss_addr,
  input  logic                         d_miss_req,
  input  logic [ADDR_W-1:0]            d_miss_addr,
  input  logic                         d_wr_req,
  input  logic [ADDR_W-1:0]            d_wr_addr,
  input  logic [DATA_W-1:0]            d_wr_data,
  output logic                         d_wr_ack,
  output logic                         mem_enable,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data_out,
  input  logic [DATA_W-1:0]            mem_data_in,
  input  logic                         mem_data_valid,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         i_fill_valid,
  output logic                         d_fill_valid,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word_num,
  output logic                         i_fill_done,
  output logic                         d_fill_done
);

  localparam int c_CNT_W = $clog2(BLK_WORDS);
  // Base clears one bit more than the word index because words are 2 bytes.
  localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'(2 * BLK_WORDS - 1);

  if ((BLK_WORDS < 2) || ((BLK_WORDS & (BLK_WORDS - 1)) != 0) || (MEM_LAT < 1))
  begin : g_param_check
    $error("cache_mem_arbiter: BLK_WORDS must be a power of 2 >= 2, MEM_LAT >= 1");
  end

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  owner_t             r_owner;
  owner_t             w_pick;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  w_miss_addr;
  logic [c_CNT_W-1:0] r_recv_cnt;
  logic               w_grant;
  logic               w_fill_fire;
  logic               w_recv_last;
  logic [ADDR_W-1:0]  w_gen_addr;
  logic               w_gen_last;

  // Arbitration between the two fill requesters.
`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_grant;
  logic   w_both;

  assign w_both = i_miss_req && d_miss_req;
  assign w_pick = w_both ? ((r_last_grant == OWN_I) ? OWN_D : OWN_I)
                         : (d_miss_req ? OWN_D : OWN_I);

  // Only contested grants move the pointer, so a lone request never skews it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= OWN_I;
    end else if (w_grant && w_both) begin
      r_last_grant <= w_pick;
    end
  end
`else
  assign w_pick = d_miss_req ? OWN_D : OWN_I;
`endif

  assign w_miss_addr = (w_pick == OWN_D) ? d_miss_addr : i_miss_addr;

  blk_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BLK_WORDS (BLK_WORDS)
  ) u_blk_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (r_state == ST_ISSUE),
    .i_base    (r_base),
    .o_addr    (w_gen_addr),
    .o_last    (w_gen_last)
  );

  // Read returns are only meaningful while a fill is outstanding; anything
  // else (including valids from a fill killed by reset) is dropped.
  assign w_fill_fire   = mem_data_valid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_recv_last   = (r_recv_cnt == c_CNT_W'(BLK_WORDS - 1));
  assign fill_data     = w_fill_fire ? mem_data_in : '0;
  assign fill_word_num = w_fill_fire ? r_recv_cnt : '0;
  assign i_fill_valid  = w_fill_fire && (r_owner == OWN_I);
  assign d_fill_valid  = w_fill_fire && (r_owner == OWN_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_D;
      r_base     <= '0;
      r_recv_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner    <= w_pick;
        r_base     <= w_miss_addr & ~c_OFF_MASK;
        r_recv_cnt <= '0;
      end else if (w_fill_fire) begin
        r_recv_cnt <= r_recv_cnt + c_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    d_wr_ack     = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_wr_req) begin
          w_state_nxt = ST_WRITE;
        end else if (i_miss_req || d_miss_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = d_wr_addr;
        mem_data_out = d_wr_data;
        d_wr_ack     = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = w_gen_addr;
        if (w_gen_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_fill_fire && w_recv_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        i_fill_done = (r_owner == OWN_I);
        d_fill_done = (r_owner == OWN_D);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_mem_arbiter                                            |
// | Purpose  : Self-checking bench for cache_mem_arbiter with a fixed-latency  |
// |            memory model and queue-based expectations.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int BW  = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic [1:0]  who;   // {i_fill_valid, d_fill_valid}
    logic [2:0]  word;
    logic [15:0] data;
  } beat_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_miss_req = 1'b0;
  logic [AW-1:0] i_miss_addr = '0;
  logic          d_miss_req = 1'b0;
  logic [AW-1:0] d_miss_addr = '0;
  logic          d_wr_req = 1'b0;
  logic [AW-1:0] d_wr_addr = '0;
  logic [DW-1:0] d_wr_data = '0;
  logic          d_wr_ack;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_valid;
  logic [DW-1:0] fill_data;
  logic          i_fill_valid;
  logic          d_fill_valid;
  logic [2:0]    fill_word_num;
  logic          i_fill_done;
  logic          d_fill_done;

  cache_mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BLK_WORDS (BW),
    .MEM_LAT   (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss_req     (i_miss_req),
    .i_miss_addr    (i_miss_addr),
    .d_miss_req     (d_miss_req),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .d_wr_ack       (d_wr_ack),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .i_fill_valid   (i_fill_valid),
    .d_fill_valid   (d_fill_valid),
    .fill_word_num  (fill_word_num),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Fixed-latency memory: a read enabled in cycle n returns in cycle n+LAT.
  // It is not tied to rst_n, so reads in flight at reset still come back.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  logic           inj_v = 1'b0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mem_enable & ~mem_wr};
    pa[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
  end

  assign mem_data_valid = pv[LAT-1] | inj_v;
  assign mem_data_in    = pv[LAT-1] ? (pa[LAT-1] ^ 16'hA5C3) : 16'h7777;

  logic [57:0] outs;
  assign outs = {mem_enable, mem_wr, mem_addr, mem_data_out, d_wr_ack, fill_data,
                 i_fill_valid, d_fill_valid, fill_word_num, i_fill_done, d_fill_done};

  logic [15:0] rd_q   [$];
  beat_t       beat_q [$];
  logic [1:0]  done_q [$];
  logic [31:0] wr_q   [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_reads(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) rd_q.push_back(base + 16'(2 * k));
  endtask

  task automatic push_beats(input bit is_d, input logic [15:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.who  = is_d ? 2'b01 : 2'b10;
      b.word = 3'(k);
      b.data = (base + 16'(2 * k)) ^ 16'hA5C3;
      beat_q.push_back(b);
    end
  endtask

  task automatic push_fill(input bit is_d, input logic [15:0] miss);
    logic [15:0] base;
    base = miss & 16'hFFF0;
    push_reads(base, BW);
    push_beats(is_d, base, BW);
    done_q.push_back(is_d ? 2'b01 : 2'b10);
  endtask

  task automatic wait_fill_done(input bit is_d, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (is_d ? d_fill_done : i_fill_done) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    if (!seen) check(is_d ? "d_done_timeout" : "i_done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_ack(output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_wr_ack) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    if (!seen) check("wr_ack_timeout", 64'(seen), 64'd1);
  endtask

  // Output monitor: every observed DUT event is matched against the queues.
  always @(negedge clk) begin
    logic        ok;
    logic [15:0] ea;
    beat_t       eb;
    logic [1:0]  ed;
    logic [31:0] ew;
    if (mem_enable && !mem_wr) begin
      ok = (rd_q.size() != 0);
      ea = '0;
      if (ok) ea = rd_q.pop_front();
      check("rd_addr", {ok, mem_addr}, {1'b1, ea});
    end
    if ((mem_enable && mem_wr) || d_wr_ack) begin
      ok = (wr_q.size() != 0);
      ew = '0;
      if (ok) ew = wr_q.pop_front();
      check("write", {ok, mem_enable, mem_wr, d_wr_ack, mem_addr, mem_data_out},
                     {1'b1, 1'b1, 1'b1, 1'b1, ew});
    end
    if (i_fill_valid || d_fill_valid) begin
      ok = (beat_q.size() != 0);
      eb = '0;
      if (ok) eb = beat_q.pop_front();
      check("fill_beat", {ok, i_fill_valid, d_fill_valid, fill_word_num, fill_data},
                         {1'b1, eb});
    end
    if (i_fill_done || d_fill_done) begin
      ok = (done_q.size() != 0);
      ed = '0;
      if (ok) ed = done_q.pop_front();
      check("fill_done", {ok, i_fill_done, d_fill_done}, {1'b1, ed});
    end
  end

  initial begin
    int t0, t1, t2, nv, stray;
    bit first_d;

    // Reset and idle outputs
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", 64'(outs), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single I-cache fill at 0x1234
    push_fill(1'b0, 16'h1234);
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 16'h1234; t0 = cyc;
    wait_fill_done(1'b0, t1);
    i_miss_req = 1'b0;
    check("i_fill_latency", 64'(t1 - t0), 64'd13);

    // Write-through in IDLE
    wr_q.push_back({16'h0040, 16'hBEEF});
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; t0 = cyc;
    wait_ack(t1);
    d_wr_req = 1'b0;
    check("wr_latency", 64'(t1 - t0), 64'd1);

    // Simultaneous pair: D first, then I
    push_fill(1'b1, 16'h4100);
    push_fill(1'b0, 16'h5208);
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 16'h5208;
    d_miss_req = 1'b1; d_miss_addr = 16'h4100;
    wait_fill_done(1'b1, t1);
    d_miss_req = 1'b0;
    wait_fill_done(1'b0, t2);
    i_miss_req = 1'b0;
    check("pair1_gap", 64'(t2 - t1), 64'd14);

    // Second simultaneous pair: fixed priority repeats D, alternation picks I
    first_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`endif
    push_fill(first_d, first_d ? 16'h6000 : 16'h7777);
    push_fill(!first_d, first_d ? 16'h7777 : 16'h6000);
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 16'h7777;
    d_miss_req = 1'b1; d_miss_addr = 16'h6000;
    wait_fill_done(first_d, t1);
    if (first_d) d_miss_req = 1'b0; else i_miss_req = 1'b0;
    wait_fill_done(!first_d, t2);
    d_miss_req = 1'b0; i_miss_req = 1'b0;
    check("pair2_gap", 64'(t2 - t1), 64'd14);

    // Write requested during an I fill waits for the fill to finish
    push_fill(1'b0, 16'h2000);
    wr_q.push_back({16'h0100, 16'h1234});
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 16'h2000;
    repeat (3) @(negedge clk);
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h1234;
    wait_fill_done(1'b0, t1);
    i_miss_req = 1'b0;
    wait_ack(t2);
    d_wr_req = 1'b0;
    check("wr_after_fill", 64'(t2 - t1), 64'd2);

    // Stray read-valid while idle
    @(posedge clk); #1 inj_v = 1'b1;
    @(negedge clk);
    check("stray_valid", {i_fill_valid, d_fill_valid, fill_data}, 64'd0);
    inj_v = 1'b0;
    repeat (2) @(posedge clk);

    // Reset after the third word of an I fill
    push_reads(16'h3000, 7);
    push_beats(1'b0, 16'h3000, 3);
    @(posedge clk); #1;
    i_miss_req = 1'b1; i_miss_addr = 16'h3000;
    nv = 0;
    for (int k = 0; k < 40 && nv < 3; k++) begin
      @(negedge clk);
      if (i_fill_valid) nv++;
    end
    if (nv != 3) check("abort_wait_timeout", 64'(nv), 64'd3);
    #2;
    rst_n = 1'b0; i_miss_req = 1'b0;
    #1 check("abort_outputs", 64'(outs), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (i_fill_valid || d_fill_valid || i_fill_done || d_fill_done) stray++;
    end
    check("late_valid_ignored", 64'(stray), 64'd0);

    // D fill whose block sits at the top of the address space
    push_fill(1'b1, 16'hFFF2);
    @(posedge clk); #1;
    d_miss_req = 1'b1; d_miss_addr = 16'hFFF2; t0 = cyc;
    wait_fill_done(1'b1, t1);
    d_miss_req = 1'b0;
    check("d_fill_latency", 64'(t1 - t0), 64'd13);
    repeat (3) @(posedge clk);

    check("rd_q_empty",   64'(rd_q.size()),   64'd0);
    check("beat_q_empty", 64'(beat_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    check("wr_q_empty",   64'(wr_q.size()),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width in bits.
REQ-003 SHALL have parameter BLK_WORDS, default 8, words per cache block (power of 2).
REQ-004 SHALL have parameter MEM_LAT, default 4, memory read latency in cycles (enable to data valid).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_miss_req  in  1  I-cache fill request, level-held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-cache missing address.
- d_miss_req  in  1  D-cache fill request, level-held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-cache missing address.
- d_wr_req  in  1  D-cache write-through request.
- d_wr_addr  in  ADDR_W  write address.
- d_wr_data  in  DATA_W  write data.
- d_wr_ack  out  1  one-cycle pulse: write issued.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  memory write data.
- mem_data_in  in  DATA_W  memory read data.
- mem_data_valid  in  1  read data valid.
- fill_data  out  DATA_W  forwarded read data.
- i_fill_valid  out  1  fill_data valid for I-cache.
- d_fill_valid  out  1  fill_data valid for D-cache.
- fill_word_num  out  log2(BLK_WORDS)  index of word on fill_data.
- i_fill_done  out  1  one-cycle pulse: I-cache block complete.
- d_fill_done  out  1  one-cycle pulse: D-cache block complete.

Function
REQ-006 SHALL implement states IDLE, WRITE, ISSUE, DRAIN, DONE.
REQ-007 IDLE SHALL select, in order: d_wr_req -> WRITE; else a fill request per arbitration (REQ-013) -> ISSUE, latching owner and block base (miss_addr with low log2(BLK_WORDS)+1 bits cleared).
REQ-008 WRITE SHALL last one cycle: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_out=d_wr_data, d_wr_ack=1; then IDLE.
REQ-009 ISSUE SHALL drive mem_enable=1, mem_wr=0 for exactly BLK_WORDS consecutive cycles, mem_addr = base + 2*issue_cnt (byte-addressed, wraps modulo 2^ADDR_W); then DRAIN.
REQ-010 Each mem_data_valid cycle SHALL forward mem_data_in to fill_data combinationally, assert owner's *_fill_valid only, drive fill_word_num = recv_cnt, then increment recv_cnt.
REQ-011 When recv_cnt reaches BLK_WORDS, SHALL enter DONE; DONE pulses owner's *_fill_done for one cycle, then IDLE.
REQ-012 mem_data_valid received outside ISSUE/DRAIN SHALL be ignored (no *_fill_valid).
REQ-013 Arbitration: when both fill requests are high in IDLE, D-cache wins unless overridden by REQ-019.
REQ-014 d_wr_req arriving during a fill SHALL wait in IDLE-return order; no write SHALL interleave with a block fill.
REQ-015 mem_enable SHALL be 0 in IDLE, DRAIN, DONE.
REQ-016 Minimum fill latency, request to *_fill_done: 1 + BLK_WORDS + MEM_LAT cycles with a fixed-latency memory.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, counters 0, owner=D, all outputs 0, including mid-fill; an in-flight read's later valids SHALL be ignored.
REQ-018 No fill_done SHALL pulse for a fill aborted by reset.

Configuration
REQ-019 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous fill requests, grant the cache not granted last (last-grant flag resets to I, so D wins first); undefined: fixed D-cache priority per REQ-013.

Structure
REQ-020 State encoding enum and owner encoding (OWN_I, OWN_D) SHALL live in shared package cache_pkg.
REQ-021 Address generator+counter SHALL be sub-module blk_addr_gen (base, issue_cnt -> mem_addr); rest flat.

Verification
REQ-022 i_miss_req, addr 0x1234 -> mem_addr 0x1230..0x123E over 8 cycles; 8 i_fill_valid with word_num 0..7; i_fill_done at cycle 13.
REQ-023 i_miss_req and d_miss_req same cycle -> D serviced first, I afterwards; with ARB_ROUND_ROBIN_EN, second simultaneous pair -> I first.
REQ-024 d_wr_req addr 0x0040 data 0xBEEF in IDLE -> one cycle mem_wr=1, d_wr_ack=1, no fill activity.
REQ-025 d_wr_req during I fill -> write issued only after i_fill_done, not interleaved.
REQ-026 rst_n low after 3rd word -> immediate IDLE, outputs 0, no fill_done, late valids ignored.
REQ-027 miss_addr 0xFFF2 -> addresses 0xFFF0..0xFFFE, no overflow artefacts.
